tdc_uart_packer: RTL and testbench



---
 rtl/tdc_uart_pkg.sv | 17 +
 rtl/tdc_word_fifo.sv | 53 +++++
 rtl/tdc_uart_packer.sv | 122 ++++++++++++
 tb/tb_tdc_uart_packer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_uart_pkg.sv
// Shared constants and types for the TDC-to-UART frame packer.
package tdc_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES       = 6;
  localparam int         IDX_W             = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ACK,
    DRAIN
  } packer_state_e;

endpackage

// File: rtl/tdc_word_fifo.sv
// Word FIFO with occupancy count; a pop frees a slot for a same-cycle write.
module tdc_word_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrValid,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdPop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doWrite;
  logic             doRead;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doRead   = rdPop && !empty;
  assign doWrite  = wrValid && (!full || doRead);
  assign level    = count;
  assign headData = mem[rdPtr];

  // NOTE: storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_uart_packer.sv
// Buffers 32-bit TDC words and sends each as a 6-byte frame (sync, 4 data MSB first, XOR)
// to a byte UART transmitter via a start pulse / busy handshake.
module tdc_uart_packer
  import tdc_uart_pkg::*;
#(
  parameter  int         FIFO_DEPTH = 8,
  parameter  logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  output logic             word_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             overflow,
  output logic             frame_done,
  output logic [LVL_W-1:0] fifo_level
);

  packer_state_e    state;
  logic [31:0]      shreg;
  logic [7:0]       checksum;
  logic [IDX_W-1:0] byteIdx;
  logic             ackWait;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pop;
  logic [31:0]      head;

  assign pop        = (state == IDLE) && !fifoEmpty && !tx_busy;
  assign word_ready = !fifoFull;

  tdc_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrValid  (word_valid),
    .wrData   (word_data),
    .rdPop    (pop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifo_level),
    .headData (head)
  );

  // A pop in the same cycle makes room, so only an un-popped full FIFO drops the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  overflow <= 1'b0;
    else if (word_valid && fifoFull && !pop)     overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      checksum   <= '0;
      byteIdx    <= '0;
      ackWait    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= head;
            checksum <= '0;
            byteIdx  <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (byteIdx == '0) begin
            tx_data <= SYNC_BYTE;
          end else if (byteIdx == LAST_IDX) begin
            tx_data <= checksum;
          end else begin
            tx_data  <= shreg[31:24];
            shreg    <= shreg << 8;
            checksum <= checksum ^ shreg[31:24];
          end
          tx_start <= 1'b1;
          ackWait  <= 1'b0;
          state    <= START;
        end
        START: state <= ACK;
        ACK: begin
          if (tx_busy) begin
            state <= DRAIN;
          end else if (ackWait) begin
            // Busy never came: assume the start was lost and pulse again.
            tx_start <= 1'b1;
            ackWait  <= 1'b0;
            state    <= START;
          end else begin
            ackWait <= 1'b1;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (byteIdx == LAST_IDX) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              byteIdx <= byteIdx + 1'b1;
              state   <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_uart_packer.sv
// Self-checking bench: transmitter model plus a byte-stream scoreboard built from frame rules.
module tb_tdc_uart_packer;

  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             word_valid = 1'b0;
  logic [31:0]      word_data = '0;
  logic             word_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             overflow;
  logic             frame_done;
  logic [LVL_W-1:0] fifo_level;

  tdc_uart_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .overflow   (overflow),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Transmitter model and scoreboard state
  logic [7:0] expQ[$];
  int         startCycQ[$];
  int         fallCycQ[$];
  int         busyCnt    = 0;
  int         holdCycles = 20;
  bit         holdBusy   = 1'b0;
  bit         dropNext   = 1'b0;
  bit         randomMode = 1'b0;
  int         cyc        = 0;
  int         startCnt   = 0;
  int         doneCnt    = 0;
  logic [7:0] lastByte   = '0;

  assign tx_busy = (busyCnt != 0) || holdBusy;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busyCnt > 0) begin
      busyCnt--;
      if (busyCnt == 0) begin
        fallCycQ.push_back(cyc);
        check("tx_data_held", tx_data, lastByte);
      end
    end
    if (frame_done) doneCnt++;
    if (tx_start) begin
      startCnt++;
      startCycQ.push_back(cyc);
      lastByte = tx_data;
      if (expQ.size() == 0) begin
        check("unexpected_start", tx_start, 1'b0);
      end else begin
        check("byte", tx_data, expQ[0]);
        if (dropNext || (randomMode && $urandom_range(7) == 0)) begin
          dropNext = 1'b0;
        end else begin
          void'(expQ.pop_front());
          busyCnt = randomMode ? int'($urandom_range(6, 2)) : holdCycles;
        end
      end
    end
  end

  // Expected frame: sync, data bytes MSB first, XOR of the data bytes.
  task automatic pushFrame(input logic [31:0] w);
    logic [7:0] b [4];
    b = '{w[31:24], w[23:16], w[15:8], w[7:0]};
    expQ.push_back(8'hA5);
    foreach (b[i]) expQ.push_back(b[i]);
    expQ.push_back(b[0] ^ b[1] ^ b[2] ^ b[3]);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    word_valid = 1'b1;
    word_data  = w;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      tick();
      n++;
    end
    check("frames_done", doneCnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sb, fb, d0, n, acc, pending;
    logic [31:0] w;

    tick();
    tick();
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", word_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single word
    sb = startCnt; d0 = doneCnt;
    pushFrame(32'h12345678);
    sendWord(32'h12345678);
    check("t1_level_after_write", fifo_level, 1);
    waitFrames(d0 + 1, 400);
    check("t1_starts", startCnt - sb, 6);
    check("t1_queue_empty", expQ.size(), 0);
    check("t1_level_end", fifo_level, 0);

    // Back-to-back all-ones / all-zeros words
    sb = startCycQ.size(); fb = fallCycQ.size(); d0 = doneCnt;
    pushFrame(32'hFFFFFFFF);
    pushFrame(32'h00000000);
    sendWord(32'hFFFFFFFF);
    sendWord(32'h00000000);
    waitFrames(d0 + 2, 800);
    check("t2_interbyte_gap", startCycQ[sb+1] - fallCycQ[fb], 2);
    check("t2_frame_gap", startCycQ[sb+6] - fallCycQ[fb+5], 3);

    // Lost first start is re-issued
    sb = startCycQ.size(); d0 = doneCnt; n = startCnt;
    dropNext = 1'b1;
    pushFrame(32'hCAFE0123);
    sendWord(32'hCAFE0123);
    waitFrames(d0 + 1, 400);
    check("t3_starts", startCnt - n, 7);
    check("t3_retry_gap", startCycQ[sb+1] - startCycQ[sb], 3);

    // Burst of nine into a stalled transmitter
    holdBusy = 1'b1; d0 = doneCnt;
    for (int i = 1; i <= 9; i++) begin
      if (i <= FIFO_DEPTH) pushFrame(32'(i));
      word_valid = 1'b1;
      word_data  = 32'(i);
      tick();
      if (i == FIFO_DEPTH) begin
        check("t4_ready_full", word_ready, 1'b0);
        check("t4_level_full", fifo_level, FIFO_DEPTH);
        check("t4_no_overflow_yet", overflow, 1'b0);
      end
    end
    word_valid = 1'b0;
    check("t4_overflow", overflow, 1'b1);
    check("t4_level_after_drop", fifo_level, FIFO_DEPTH);
    holdBusy = 1'b0;
    waitFrames(d0 + FIFO_DEPTH, FIFO_DEPTH * 200);

    // Reset while draining byte index 3
    sb = startCnt;
    pushFrame(32'hDEADBEEF);
    sendWord(32'hDEADBEEF);
    sendWord(32'h11111111);
    sendWord(32'h22222222);
    n = 0;
    while (startCnt < sb + 4 && n < 500) begin
      tick();
      n++;
    end
    check("t5_reach_idx3", startCnt - sb, 4);
    tick();
    tick();
    check("t5_pre_data", tx_data, 8'hBE);
    check("t5_pre_level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    busyCnt = 0;
    expQ.delete();
    check("t5_rst_tx_data", tx_data, 8'h00);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_ready", word_ready, 1'b1);
    check("t5_rst_overflow", overflow, 1'b0);
    check("t5_rst_tx_start", tx_start, 1'b0);
    check("t5_rst_frame_done", frame_done, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    n = startCnt; d0 = doneCnt;
    repeat (40) tick();
    check("t5_quiet_starts", startCnt - n, 0);
    check("t5_quiet_done", doneCnt - d0, 0);
    check("t5_quiet_level", fifo_level, 0);
    pushFrame(32'h0BADF00D);
    sendWord(32'h0BADF00D);
    waitFrames(d0 + 1, 400);

    // Write and pop in the same cycle while full
    holdBusy = 1'b1; d0 = doneCnt;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pushFrame(32'hA0A0_0000 + 32'(i));
      sendWord(32'hA0A0_0000 + 32'(i));
    end
    check("t6_level_full", fifo_level, FIFO_DEPTH);
    check("t6_ready_full", word_ready, 1'b0);
    pushFrame(32'h5A5A5A5A);
    holdBusy   = 1'b0;
    word_valid = 1'b1;
    word_data  = 32'h5A5A5A5A;
    tick();
    word_valid = 1'b0;
    check("t6_level_kept", fifo_level, FIFO_DEPTH);
    check("t6_no_overflow", overflow, 1'b0);
    waitFrames(d0 + FIFO_DEPTH + 1, (FIFO_DEPTH + 1) * 200);

    // Randomised traffic, transmitter timing and lost starts
    randomMode = 1'b1; d0 = doneCnt; acc = 0;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(4)) tick();
      pending = acc - (doneCnt - d0);
      if (pending < FIFO_DEPTH) begin
        w = $urandom;
        pushFrame(w);
        check("rnd_ready", word_ready, 1'b1);
        sendWord(w);
        acc++;
      end else begin
        tick();
      end
    end
    waitFrames(d0 + acc, 5000);
    randomMode = 1'b0;
    tick();
    check("end_queue_empty", expQ.size(), 0);
    check("end_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
